// File: rtl/joy_pkg.sv
// joy_pkg: shared direction indices, mode codes and axis type for the joystick resolver.
`default_nettype none

package joy_pkg;

   localparam int JOY_R = 0;
   localparam int JOY_L = 1;
   localparam int JOY_D = 2;
   localparam int JOY_U = 3;

   localparam int JOY_2WAY = 0;
   localparam int JOY_4WAY = 1;
   localparam int JOY_8WAY = 2;

   typedef enum logic {
      AXIS_H = 1'b0,
      AXIS_V = 1'b1
   } axis_t;

endpackage

`default_nettype wire

// File: rtl/joy_chan.sv
// joy_chan: one player's sync, debounce, last-pressed resolution and mode restriction.
`default_nettype none

module joy_chan
   import joy_pkg::*;
#(
   parameter int MODE            = JOY_2WAY,
   parameter int DEBOUNCE_CYCLES = 1
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic [3:0] indir,
   output logic [3:0] outdir,
   output logic       changed
);

   localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

   logic [3:0]  s1, s2, db, dbq, prev_out;
   logic [15:0] cnt;
   logic        last_h_is_l, last_v_is_u;
   axis_t       last_axis;

   logic [3:0]  new_press;
   logic        h_new, v_new;
   logic        nxt_h_is_l, nxt_v_is_u;
   axis_t       nxt_axis;
   logic [1:0]  h, v;
   logic [3:0]  resolved;

   always_comb begin
      new_press = db & ~dbq;
      h_new     = new_press[JOY_L] | new_press[JOY_R];
      v_new     = new_press[JOY_U] | new_press[JOY_D];

      // L and U take priority when both members of a pair arrive together
      nxt_h_is_l = last_h_is_l;
      if (new_press[JOY_L])      nxt_h_is_l = 1'b1;
      else if (new_press[JOY_R]) nxt_h_is_l = 1'b0;

      nxt_v_is_u = last_v_is_u;
      if (new_press[JOY_U])      nxt_v_is_u = 1'b1;
      else if (new_press[JOY_D]) nxt_v_is_u = 1'b0;

      nxt_axis = last_axis;
      if (h_new && !v_new)      nxt_axis = AXIS_H;
      else if (v_new && !h_new) nxt_axis = AXIS_V;

      h = {db[JOY_L], db[JOY_R]};
      if (&h) h = nxt_h_is_l ? 2'b10 : 2'b01;
      v = {db[JOY_U], db[JOY_D]};
      if (&v) v = nxt_v_is_u ? 2'b10 : 2'b01;

      if (MODE == JOY_2WAY) begin
         v = 2'b00;
      end else if (MODE == JOY_4WAY && (|h) && (|v)) begin
         if (nxt_axis == AXIS_H) v = 2'b00;
         else                    h = 2'b00;
      end

      resolved = {v, h};
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         s1          <= '0;
         s2          <= '0;
         db          <= '0;
         dbq         <= '0;
         cnt         <= '0;
         last_h_is_l <= 1'b0;
         last_v_is_u <= 1'b1;
         last_axis   <= AXIS_H;
         outdir      <= '0;
         prev_out    <= '0;
         changed     <= 1'b0;
      end else begin
         s1  <= indir;
         s2  <= s1;
         dbq <= db;
         if (s2 == db) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            db  <= s2;
            cnt <= '0;
         end else begin
            cnt <= cnt + 16'd1;
         end
         last_h_is_l <= nxt_h_is_l;
         last_v_is_u <= nxt_v_is_u;
         last_axis   <= nxt_axis;
         outdir      <= resolved;
         // prev_out trails outdir by one edge so the pulse lands the cycle after the update
         prev_out    <= outdir;
         changed     <= (outdir != prev_out);
      end
   end

endmodule

`default_nettype wire

// File: rtl/joy_resolve.sv
// joy_resolve: CHANNELS independent joystick resolvers packed into 4-bit {U,D,L,R} slices.
`default_nettype none

module joy_resolve
   import joy_pkg::*;
#(
   parameter int CHANNELS        = 2,
   parameter int MODE            = JOY_2WAY,
   parameter int DEBOUNCE_CYCLES = 1
) (
   input  logic                  clk_sys,
   input  logic                  reset_n,
   input  logic [4*CHANNELS-1:0] indir,
   output logic [4*CHANNELS-1:0] outdir,
   output logic [CHANNELS-1:0]   changed
);

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      joy_chan #(
         .MODE            (MODE),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_chan (
         .clk_sys (clk_sys),
         .reset_n (reset_n),
         .indir   (indir[4*c +: 4]),
         .outdir  (outdir[4*c +: 4]),
         .changed (changed[c])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_joy_resolve.sv
// tb_joy_resolve: directed scenarios plus randomized traffic against a timestamp-based reference model.
`default_nettype none

module tb_joy_resolve;

   logic       clk_sys = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] in_v [4];
   wire  [7:0] o0, o1, o2, o3;
   wire  [1:0] c0, c1, c2, c3;
   wire  [7:0] out_v [4];
   wire  [1:0] chg_v [4];

   int checks = 0;
   int fails  = 0;

   assign out_v[0] = o0;
   assign out_v[1] = o1;
   assign out_v[2] = o2;
   assign out_v[3] = o3;
   assign chg_v[0] = c0;
   assign chg_v[1] = c1;
   assign chg_v[2] = c2;
   assign chg_v[3] = c3;

   always #5 clk_sys = ~clk_sys;

   joy_resolve #(.CHANNELS(2), .MODE(0), .DEBOUNCE_CYCLES(1)) u0 (
      .clk_sys(clk_sys), .reset_n(reset_n), .indir(in_v[0]), .outdir(o0), .changed(c0));
   joy_resolve #(.CHANNELS(2), .MODE(1), .DEBOUNCE_CYCLES(1)) u1 (
      .clk_sys(clk_sys), .reset_n(reset_n), .indir(in_v[1]), .outdir(o1), .changed(c1));
   joy_resolve #(.CHANNELS(2), .MODE(2), .DEBOUNCE_CYCLES(1)) u2 (
      .clk_sys(clk_sys), .reset_n(reset_n), .indir(in_v[2]), .outdir(o2), .changed(c2));
   joy_resolve #(.CHANNELS(2), .MODE(2), .DEBOUNCE_CYCLES(4)) u3 (
      .clk_sys(clk_sys), .reset_n(reset_n), .indir(in_v[3]), .outdir(o3), .changed(c3));

   // Reference model: press order is kept as edge timestamps rather than last-pressed flags
   int         mode_of [4] = '{0, 1, 2, 2};
   int         deb_of  [4] = '{1, 1, 1, 4};
   logic [3:0] m_s1 [4][2];
   logic [3:0] m_s2 [4][2];
   logic [3:0] m_db [4][2];
   logic [3:0] m_exp [4][2];
   logic [3:0] m_expq [4][2];
   logic       m_chg [4][2];
   int         m_run [4][2];
   int         m_t [4][2][4];
   int         m_tah [4][2];
   int         m_tav [4][2];
   int         ecount = 0;

   task automatic model_reset();
      for (int i = 0; i < 4; i++)
         for (int c = 0; c < 2; c++) begin
            m_s1[i][c] = '0; m_s2[i][c] = '0; m_db[i][c] = '0;
            m_exp[i][c] = '0; m_expq[i][c] = '0; m_chg[i][c] = 1'b0;
            m_run[i][c] = 0; m_tah[i][c] = -1; m_tav[i][c] = -1;
            for (int b = 0; b < 4; b++) m_t[i][c][b] = -1;
         end
   endtask

   function automatic logic [3:0] model_resolve(int i, int c);
      logic [1:0] h, v;
      h = m_db[i][c][1:0];
      v = m_db[i][c][3:2];
      if (h == 2'b11)
         h = (m_t[i][c][1] > m_t[i][c][0] || (m_t[i][c][1] == m_t[i][c][0] && m_t[i][c][1] >= 0))
             ? 2'b10 : 2'b01;
      if (v == 2'b11)
         v = (m_t[i][c][3] >= m_t[i][c][2]) ? 2'b10 : 2'b01;
      if (mode_of[i] == 0) v = 2'b00;
      else if (mode_of[i] == 1 && h != 2'b00 && v != 2'b00) begin
         if (m_tav[i][c] > m_tah[i][c]) h = 2'b00;
         else                           v = 2'b00;
      end
      return {v, h};
   endfunction

   task automatic model_step();
      logic [3:0] s2old, rises;
      ecount++;
      for (int i = 0; i < 4; i++)
         for (int c = 0; c < 2; c++) begin
            m_chg[i][c]  = (m_exp[i][c] != m_expq[i][c]);
            m_expq[i][c] = m_exp[i][c];
            m_exp[i][c]  = model_resolve(i, c);
            s2old        = m_s2[i][c];
            m_s2[i][c]   = m_s1[i][c];
            m_s1[i][c]   = in_v[i][4*c +: 4];
            if (s2old == m_db[i][c]) m_run[i][c] = 0;
            else if (m_run[i][c] == deb_of[i] - 1) begin
               rises = s2old & ~m_db[i][c];
               for (int b = 0; b < 4; b++) if (rises[b]) m_t[i][c][b] = ecount;
               if (rises[1:0] != 0 && rises[3:2] == 0) m_tah[i][c] = ecount;
               if (rises[3:2] != 0 && rises[1:0] == 0) m_tav[i][c] = ecount;
               m_db[i][c]  = s2old;
               m_run[i][c] = 0;
            end else m_run[i][c]++;
         end
   endtask

   always @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) model_reset();
      else          model_step();
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic do_reset();
      for (int i = 0; i < 4; i++) in_v[i] = '0;
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_v[i] !== 8'h00) begin
            fails++; $display("FAIL reset_outdir u%0d: got %h want 00", i, out_v[i]);
         end
         checks++;
         if (chg_v[i] !== 2'b00) begin
            fails++; $display("FAIL reset_changed u%0d: got %b want 00", i, chg_v[i]);
         end
      end
   endtask

   task automatic test_mode0();
      logic [3:0] exp;
      do_reset();
      in_v[0] = 8'h01;
      for (int k = 1; k <= 6; k++) begin
         tick();
         exp = (k >= 4) ? 4'b0001 : 4'b0000;
         checks++;
         if (out_v[0][3:0] !== exp) begin
            fails++; $display("FAIL m0_latency tick%0d: got %b want %b", k, out_v[0][3:0], exp);
         end
         checks++;
         if (chg_v[0][0] !== (k == 5)) begin
            fails++; $display("FAIL m0_changed tick%0d: got %b want %b", k, chg_v[0][0], (k == 5));
         end
      end
      in_v[0] = 8'h03;
      repeat (4) tick();
      checks++;
      if (out_v[0][3:0] !== 4'b0010) begin
         fails++; $display("FAIL m0_add_l: got %b want 0010", out_v[0][3:0]);
      end
      in_v[0] = 8'h01;
      repeat (4) tick();
      checks++;
      if (out_v[0][3:0] !== 4'b0001) begin
         fails++; $display("FAIL m0_release_l: got %b want 0001", out_v[0][3:0]);
      end
      in_v[0] = 8'h00;
      repeat (4) tick();
      in_v[0] = 8'h03;
      repeat (4) tick();
      checks++;
      if (out_v[0][3:0] !== 4'b0010) begin
         fails++; $display("FAIL m0_lr_same: got %b want 0010", out_v[0][3:0]);
      end
      in_v[0] = 8'h0B;
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++;
         if (out_v[0][3:0] !== 4'b0010) begin
            fails++; $display("FAIL m0_u_hidden: got %b want 0010", out_v[0][3:0]);
         end
      end
   endtask

   task automatic test_mode1();
      do_reset();
      in_v[1] = 8'h09;
      repeat (4) tick();
      checks++;
      if (out_v[1][3:0] !== 4'b0001) begin
         fails++; $display("FAIL m1_ur_same: got %b want 0001", out_v[1][3:0]);
      end
      in_v[1] = 8'h00;
      repeat (4) tick();
      in_v[1] = 8'h01;
      repeat (4) tick();
      in_v[1] = 8'h09;
      repeat (4) tick();
      checks++;
      if (out_v[1][3:0] !== 4'b1000) begin
         fails++; $display("FAIL m1_add_u: got %b want 1000", out_v[1][3:0]);
      end
      in_v[1] = 8'h01;
      repeat (4) tick();
      checks++;
      if (out_v[1][3:0] !== 4'b0001) begin
         fails++; $display("FAIL m1_release_u: got %b want 0001", out_v[1][3:0]);
      end
   endtask

   task automatic test_mode2();
      do_reset();
      in_v[2] = 8'h09;
      repeat (4) tick();
      checks++;
      if (out_v[2][3:0] !== 4'b1001) begin
         fails++; $display("FAIL m2_ur: got %b want 1001", out_v[2][3:0]);
      end
      in_v[2] = 8'h0D;
      repeat (4) tick();
      checks++;
      if (out_v[2][3:0] !== 4'b0101) begin
         fails++; $display("FAIL m2_add_d: got %b want 0101", out_v[2][3:0]);
      end
   endtask

   task automatic test_debounce();
      logic [3:0] exp;
      do_reset();
      in_v[3] = 8'h01;
      repeat (3) tick();
      in_v[3] = 8'h00;
      for (int k = 0; k < 10; k++) begin
         tick();
         checks++;
         if (out_v[3][3:0] !== 4'b0000) begin
            fails++; $display("FAIL db_short_pulse: got %b want 0000", out_v[3][3:0]);
         end
      end
      in_v[3] = 8'h01;
      for (int k = 1; k <= 7; k++) begin
         tick();
         if (k == 4) in_v[3] = 8'h00;
         exp = (k == 7) ? 4'b0001 : 4'b0000;
         checks++;
         if (out_v[3][3:0] !== exp) begin
            fails++; $display("FAIL db_long_pulse tick%0d: got %b want %b", k, out_v[3][3:0], exp);
         end
      end
      repeat (12) tick();
      for (int k = 0; k < 24; k++) begin
         in_v[3] = ((k / 2) % 2 == 0) ? 8'h01 : 8'h00;
         tick();
         checks++;
         if (out_v[3][3:0] !== 4'b0000 || chg_v[3][0] !== 1'b0) begin
            fails++; $display("FAIL db_toggle: outdir %b changed %b want 0000/0", out_v[3][3:0], chg_v[3][0]);
         end
      end
   endtask

   task automatic test_channels();
      do_reset();
      in_v[0] = 8'h21;
      repeat (4) tick();
      checks++;
      if (out_v[0] !== 8'h21) begin
         fails++; $display("FAIL ch_both: got %h want 21", out_v[0]);
      end
      in_v[0] = 8'h20;
      repeat (4) tick();
      checks++;
      if (out_v[0] !== 8'h20) begin
         fails++; $display("FAIL ch_independent: got %h want 20", out_v[0]);
      end
      tick();
      checks++;
      if (chg_v[0] !== 2'b01) begin
         fails++; $display("FAIL ch_changed: got %b want 01", chg_v[0]);
      end
      repeat (3) tick();
      reset_n = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_v[i] !== 8'h00 || chg_v[i] !== 2'b00) begin
            fails++; $display("FAIL async_reset u%0d: outdir %h changed %b want 00/00", i, out_v[i], chg_v[i]);
         end
      end
      #1;
      reset_n = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++;
         if (out_v[0] !== ((k == 4) ? 8'h20 : 8'h00)) begin
            fails++; $display("FAIL reset_rehold tick%0d: got %h", k, out_v[0]);
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 800; n++) begin
         if (n == 400) reset_n = 1'b0;
         if (n == 402) reset_n = 1'b1;
         tick();
         for (int i = 0; i < 4; i++)
            for (int c = 0; c < 2; c++) begin
               checks++;
               if (out_v[i][4*c +: 4] !== m_exp[i][c] || chg_v[i][c] !== m_chg[i][c]) begin
                  fails++;
                  $display("FAIL random u%0d ch%0d cyc%0d: outdir %b changed %b want %b/%b",
                           i, c, n, out_v[i][4*c +: 4], chg_v[i][c], m_exp[i][c], m_chg[i][c]);
               end
            end
         for (int i = 0; i < 4; i++)
            if ($urandom_range(0, (i == 3) ? 7 : 3) == 0) in_v[i] = 8'($urandom);
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) in_v[i] = '0;
      test_reset();
      test_mode0();
      test_mode1();
      test_mode2();
      test_debounce();
      test_channels();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

`default_nettype wire
